// File: rtl/hash_table_pkg.sv
// Shared types for the hash-table engines and their result path.
package hash_table;

    typedef struct packed {
        logic        hit;
        logic [15:0] key;
        logic [31:0] value;
    } ht_result_t;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } ht_arb_mode_t;

endpackage

// File: rtl/ht_res_skid.sv
// Two-entry valid/ready skid buffer: main register drives the outputs, skid catches
// the one extra beat taken while main is stalled. in_ready_o comes straight from a flop.
module ht_res_skid #(
    parameter type T = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  T     in_data_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output T     out_data_o,
    output logic out_valid_o,
    input  logic out_ready_i
);

    T     main_q, main_d;
    T     skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic acc;

    assign in_ready_o  = !skid_vld_q;
    assign acc         = in_valid_i && in_ready_o;
    assign out_data_o  = main_q;
    assign out_valid_o = main_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q || out_ready_i) begin
            // Main is free this cycle; skid has priority so order is kept.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = acc;
                if (acc) begin
                    main_d = in_data_i;
                end
            end
        end else if (acc) begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
        skid_q <= skid_d;
    end

endmodule

// File: rtl/ht_res_arb.sv
// N-to-1 merger of per-engine hash-table result streams with round-robin or
// fixed-priority grant, source-channel tagging and a registered skid output stage.
module ht_res_arb
    import hash_table::*;
#(
    parameter int           CHANNELS = 4,
    parameter ht_arb_mode_t ARB_MODE = ARB_RR,
    localparam int          CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  ht_result_t [CHANNELS-1:0]    res_i,
    input  logic [CHANNELS-1:0]          res_valid_i,
    output logic [CHANNELS-1:0]          res_ready_o,
    output ht_result_t                   res_o,
    output logic [CH_W-1:0]              res_chan_o,
    output logic                         res_valid_o,
    input  logic                         res_ready_i
);

    typedef struct packed {
        ht_result_t      res;
        logic [CH_W-1:0] chan;
    } payload_t;

    logic [CHANNELS-1:0] grant;
    logic [CH_W-1:0]     gidx;
    logic                found;
    logic                can_accept;
    logic                acc;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    payload_t            in_pl, out_pl;

    // Search starts at rr_ptr in round-robin mode and at 0 in fixed mode.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            logic [CH_W-1:0] cidx;
            cidx = CH_W'((((ARB_MODE == ARB_RR) ? int'(rr_ptr_q) : 0) + i) % CHANNELS);
            if (!found && res_valid_i[cidx]) begin
                found = 1'b1;
                gidx  = cidx;
            end
        end
        grant[gidx] = found;
    end

    assign acc         = found && can_accept && !rst_i;
    assign res_ready_o = grant & {CHANNELS{can_accept && !rst_i}};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (acc) begin
            rr_ptr_d = CH_W'((int'(gidx) + 1) % CHANNELS);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign in_pl.res  = res_i[gidx];
    assign in_pl.chan = gidx;

    ht_res_skid #(
        .T(payload_t)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_data_i  (in_pl),
        .in_valid_i (found && !rst_i),
        .in_ready_o (can_accept),
        .out_data_o (out_pl),
        .out_valid_o(res_valid_o),
        .out_ready_i(res_ready_i)
    );

    assign res_o      = out_pl.res;
    assign res_chan_o = (CHANNELS > 1) ? out_pl.chan : '0;

endmodule

// File: tb/tb_ht_res_arb.sv
// Scoreboard bench: two merger instances (round-robin and fixed priority) driven by
// independent random producers, predicted by a queue-level model of the merger.
module tb_ht_res_arb;
    import hash_table::*;

    localparam int NCH = 4;

    typedef struct packed {
        ht_result_t r;
        logic [1:0] c;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        vld  [2];
    ht_result_t [NCH-1:0]  dat  [2];
    logic [NCH-1:0]        rdy  [2];
    ht_result_t            out  [2];
    logic [1:0]            chan [2];
    logic                  ovld [2];
    logic                  ordy [2];
    logic [NCH-1:0]        xfer [2];

    exp_t           sb [2][$];
    int             occ [2];
    int             rr [2];
    int             seq [2][NCH];
    logic [NCH-1:0] allow;
    int             vprob, rprob;
    logic           rst_next;
    int             n_tests = 0;
    int             n_fail  = 0;

    always #5 clk = ~clk;

    ht_res_arb #(.CHANNELS(NCH), .ARB_MODE(ARB_RR)) u_rr (
        .clk_i(clk), .rst_i(rst), .res_i(dat[0]), .res_valid_i(vld[0]),
        .res_ready_o(rdy[0]), .res_o(out[0]), .res_chan_o(chan[0]),
        .res_valid_o(ovld[0]), .res_ready_i(ordy[0])
    );

    ht_res_arb #(.CHANNELS(NCH), .ARB_MODE(ARB_FIXED)) u_fx (
        .clk_i(clk), .rst_i(rst), .res_i(dat[1]), .res_valid_i(vld[1]),
        .res_ready_o(rdy[1]), .res_o(out[1]), .res_chan_o(chan[1]),
        .res_valid_o(ovld[1]), .res_ready_i(ordy[1])
    );

    task automatic chk(string name, int u, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (unit %0d) at %0t: got %0h, expected %0h", name, u, $time, act, exp);
        end
    endtask

    function automatic ht_result_t mk(int u, int c);
        ht_result_t r;
        seq[u][c]++;
        r.hit   = 1'($urandom_range(1));
        r.key   = 16'(c * 4096 + (seq[u][c] % 4096));
        r.value = $urandom;
        return r;
    endfunction

    // Reference: buffer holds at most two results; accept possible only when fewer than
    // two are held; grant is the first valid channel from the pointer (RR) or from 0.
    task automatic model_step(int u);
        logic [NCH-1:0] er;
        int             g;
        int             drain;
        er = '0;
        g  = -1;
        if (!rst && occ[u] < 2) begin
            for (int i = 0; i < NCH; i++) begin
                int c;
                c = (u == 0) ? (rr[u] + i) % NCH : i;
                if (g < 0 && vld[u][c]) g = c;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("ready_o", u, 64'(rdy[u]), 64'(er));
        chk("ready_onehot", u, 64'($onehot0(rdy[u])), 64'(1));
        chk("valid_o", u, 64'(ovld[u]), 64'(occ[u] != 0));
        xfer[u] = vld[u] & rdy[u];
        drain = (occ[u] > 0 && ordy[u]) ? 1 : 0;
        if (g >= 0) begin
            exp_t e;
            e.r = dat[u][g];
            e.c = 2'(g);
            sb[u].push_back(e);
            rr[u] = (g + 1) % NCH;
        end
        occ[u] = occ[u] - drain + ((g >= 0) ? 1 : 0);
        if (rst) begin
            occ[u] = 0;
            rr[u]  = 0;
            sb[u].delete();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst = rst_next;
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < NCH; c++) begin
                if (xfer[u][c]) vld[u][c] = 1'b0;
                if (!vld[u][c] && allow[c] && ($urandom_range(99) < vprob)) begin
                    vld[u][c] = 1'b1;
                    dat[u][c] = mk(u, c);
                end
            end
            ordy[u] = !rst && ($urandom_range(99) < rprob);
        end
        #3;
        for (int u = 0; u < 2; u++) model_step(u);
    endtask

    task automatic phase(logic [NCH-1:0] a, int vp, int rp, int n);
        allow = a;
        vprob = vp;
        rprob = rp;
        repeat (n) cycle();
    endtask

    // Output monitor: every transfer on the merged port must match the scoreboard head.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ovld[u] && ordy[u]) begin
                if (sb[u].size() == 0) begin
                    chk("spurious_out", u, 64'(ovld[u]), 64'(0));
                end else begin
                    exp_t e;
                    e = sb[u].pop_front();
                    chk("res_o", u, 64'(out[u]), 64'(e.r));
                    chk("res_chan_o", u, 64'(chan[u]), 64'(e.c));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rst_next = 1'b1;
        allow    = '0;
        vprob    = 0;
        rprob    = 0;
        for (int u = 0; u < 2; u++) begin
            vld[u]  = '0;
            dat[u]  = '0;
            ordy[u] = 1'b0;
            xfer[u] = '0;
            occ[u]  = 0;
            rr[u]   = 0;
            for (int c = 0; c < NCH; c++) seq[u][c] = 0;
        end
        repeat (3) cycle();
        for (int u = 0; u < 2; u++) begin
            chk("reset_res_o", u, 64'(out[u]), 64'(0));
            chk("reset_chan_o", u, 64'(chan[u]), 64'(0));
        end
        rst_next = 1'b0;

        phase(4'b0100, 100, 100, 4);
        phase(4'b0000, 0, 100, 3);
        phase(4'b1111, 100, 100, 20);
        phase(4'b1010, 100, 100, 10);
        phase(4'b1000, 100, 100, 8);
        phase(4'b0000, 0, 100, 4);
        phase(4'b0001, 100, 0, 5);
        phase(4'b0001, 100, 100, 6);
        phase(4'b0000, 0, 100, 3);
        phase(4'b1111, 100, 0, 4);
        rst_next = 1'b1;
        cycle();
        rst_next = 1'b0;
        phase(4'b1111, 100, 100, 6);

        for (int s = 0; s < 50; s++) begin
            phase(4'($urandom_range(15)), $urandom_range(20, 100), $urandom_range(0, 100), 200);
        end

        allow = '0;
        rprob = 100;
        for (int k = 0; k < 100; k++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && vld[0] == '0 && vld[1] == '0) break;
            cycle();
        end
        repeat (2) cycle();
        for (int u = 0; u < 2; u++) begin
            chk("drain_left", u, 64'(sb[u].size()), 64'(0));
            chk("drain_valid", u, 64'(ovld[u]), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
